// File: rtl/bcd_adder_serial.sv
// Digit-serial N-digit BCD adder/subtractor.
// Operands are latched on i_start and processed one BCD digit per clock,
// least-significant digit first. Results hold until the next accepted start.
module bcd_adder_serial #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_sub,
  input  logic                  i_cin,
  input  logic [4*DIGITS-1:0]   i_a,
  input  logic [4*DIGITS-1:0]   i_b,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_sum,
  output logic                  o_cout,
  output logic                  o_error
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_sub;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [W-1:0]       r_sum;
  logic               r_cout;
  logic               r_error;

  logic               w_bad;
  logic [3:0]         w_a_dig;
  logic [3:0]         w_b_dig;
  logic [3:0]         w_bd;
  logic [4:0]         w_s;
  logic [3:0]         w_dig;
  logic               w_carry;
  logic               w_last;

  // Flag any non-BCD digit on the live operand inputs
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if ((i_a[4*i +: 4] > 4'd9) || (i_b[4*i +: 4] > 4'd9)) begin
        w_bad = 1'b1;
      end
    end
  end

  // Single-digit add with nine's-complement of B for subtraction and decimal correction
  always_comb begin
    w_a_dig = 4'd0;
    w_b_dig = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_a_dig = r_a[4*i +: 4];
        w_b_dig = r_b[4*i +: 4];
      end
    end
    w_bd = r_sub ? 4'(4'd9 - w_b_dig) : w_b_dig;
    w_s  = {1'b0, w_a_dig} + {1'b0, w_bd} + {4'd0, r_carry};
    if (w_s > 5'd9) begin
      w_dig   = 4'(w_s + 5'd6);
      w_carry = 1'b1;
    end else begin
      w_dig   = w_s[3:0];
      w_carry = 1'b0;
    end
    w_last = (r_cnt == CNT_W'(DIGITS - 1));
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_sub   <= i_sub;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_error <= 1'b0;
            r_cnt   <= '0;
            if (w_bad) begin
              r_error <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_carry <= i_sub | i_cin;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          for (int i = 0; i < int'(DIGITS); i++) begin
            if (r_cnt == CNT_W'(i)) begin
              r_sum[4*i +: 4] <= w_dig;
            end
          end
          r_carry <= w_carry;
          if (w_last) begin
            r_cout  <= w_carry;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_sum   = r_sum;
  assign o_cout  = r_cout;
  assign o_error = r_error;

endmodule

// File: tb/tb_bcd_adder_serial.sv
// Self-checking bench for bcd_adder_serial: directed cases plus random
// operations checked against an integer-arithmetic decimal model.
module tb_bcd_adder_serial;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;
  localparam int          MODV   = 10000;

  logic         clk;
  logic         rst;
  logic         i_start;
  logic         i_sub;
  logic         i_cin;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_sum;
  logic         o_cout;
  logic         o_error;

  int n_chk;
  int n_fail;

  bcd_adder_serial #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_sub   (i_sub),
    .i_cin   (i_cin),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_sum   (o_sum),
    .o_cout  (o_cout),
    .o_error (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit bcd_ok(input logic [W-1:0] v);
    bit ok;
    logic [3:0] d;
    ok = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = v[4*i +: 4];
      if (d > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int r;
    logic [3:0] d;
    r = 0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      d = v[4*i +: 4];
      r = r * 10 + int'(d);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = n;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal reference: plain integer add/subtract modulo 10^DIGITS
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic cin, output logic [W-1:0] esum, output logic ecout,
                       output logic eerr);
    int av, bv, t;
    if (!bcd_ok(a) || !bcd_ok(b)) begin
      esum = '0; ecout = 1'b0; eerr = 1'b1;
    end else begin
      av = bcd2int(a);
      bv = bcd2int(b);
      eerr = 1'b0;
      if (sub) begin
        if (av >= bv) begin
          esum = int2bcd(av - bv); ecout = 1'b1;
        end else begin
          esum = int2bcd(MODV - (bv - av)); ecout = 1'b0;
        end
      end else begin
        t = av + bv + int'(cin);
        esum = int2bcd(t % MODV);
        ecout = (t >= MODV);
      end
    end
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < int'(DIGITS); i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // One operation from IDLE; optionally scribble inputs while it runs
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin, input bit scramble);
    logic [W-1:0] esum;
    logic ecout, eerr;
    int cyc;
    model(a, b, sub, cin, esum, ecout, eerr);
    i_a = a; i_b = b; i_sub = sub; i_cin = cin; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    cyc = 0;
    while (!o_done && cyc < 20) begin
      chk({tag, " busy"}, 32'(o_busy), 32'(!eerr && cyc < int'(DIGITS)));
      if (scramble) begin
        i_a = rand_bcd(); i_b = rand_bcd();
        i_sub = 1'($urandom_range(0, 1)); i_cin = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), eerr ? 32'd1 : 32'(DIGITS + 1));
    chk({tag, " sum"}, 32'(o_sum), 32'(esum));
    chk({tag, " cout"}, 32'(o_cout), 32'(ecout));
    chk({tag, " error"}, 32'(o_error), 32'(eerr));
    chk({tag, " busy@done"}, 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, " done pulse"}, 32'(o_done), 32'd0);
    chk({tag, " sum hold"}, 32'(o_sum), 32'(esum));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int phase;
    n_chk = 0; n_fail = 0;
    rst = 1'b1; i_start = 1'b0; i_sub = 1'b0; i_cin = 1'b0; i_a = '0; i_b = '0;
    #2;
    chk("reset busy", 32'(o_busy), 32'd0);
    chk("reset done", 32'(o_done), 32'd0);
    chk("reset sum", 32'(o_sum), 32'd0);
    chk("reset cout", 32'(o_cout), 32'd0);
    chk("reset error", 32'(o_error), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add0999", 16'h0999, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("wrap",    16'h9999, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_op("cin",     16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_op("sub_ge",  16'h0500, 16'h0123, 1'b1, 1'b0, 1'b0);
    run_op("sub_lt",  16'h0123, 16'h0500, 1'b1, 1'b1, 1'b1);
    run_op("sub_eq",  16'h4567, 16'h4567, 1'b1, 1'b0, 1'b0);
    run_op("bad",     16'h0A00, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("after",   16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);

    // Start held high: accepts only in IDLE, one op every DIGITS+2 edges
    i_a = 16'h1234; i_b = 16'h4321; i_sub = 1'b0; i_cin = 1'b0; i_start = 1'b1;
    for (int t = 0; t < 4 * int'(DIGITS + 2); t++) begin
      @(posedge clk); #1;
      phase = t % int'(DIGITS + 2);
      chk("hs busy", 32'(o_busy), 32'(phase < int'(DIGITS)));
      chk("hs done", 32'(o_done), 32'(phase == int'(DIGITS + 1)));
      if (phase == int'(DIGITS + 1)) begin
        chk("hs sum", 32'(o_sum), 32'h5555);
        chk("hs cout", 32'(o_cout), 32'd0);
      end
      if (phase == 1) begin i_a = rand_bcd(); i_b = rand_bcd(); end
      if (phase == 3) begin i_a = 16'h1234; i_b = 16'h4321; end
    end
    i_start = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of RUN
    i_a = 16'h9999; i_b = 16'h9999; i_sub = 1'b0; i_cin = 1'b1; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst busy", 32'(o_busy), 32'd0);
    chk("arst done", 32'(o_done), 32'd0);
    chk("arst sum", 32'(o_sum), 32'd0);
    chk("arst cout", 32'(o_cout), 32'd0);
    chk("arst error", 32'(o_error), 32'd0);
    #3;
    rst = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      chk("arst no done", 32'(o_done), 32'd0);
      chk("arst idle", 32'(o_busy), 32'd0);
    end
    run_op("post_rst", 16'h2500, 16'h7500, 1'b0, 1'b0, 1'b0);

    // Random operations, occasionally with a non-BCD digit
    for (int n = 0; n < 40; n++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
        else rb[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      end
      run_op("rand", ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
